// File: rtl/count_scan_display_if.sv
// Counter-to-display bus: upstream count and blank in, display drive and
// roll-over status out.
interface count_scan_display_if;
    logic [3:0] q;
    logic       blank;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] wraps;
    logic       wrap_pulse;

    modport master (output q, blank, input seg, an, wraps, wrap_pulse);
    modport slave  (input q, blank, output seg, an, wraps, wrap_pulse);
endinterface

// File: rtl/count_scan_display.sv
// Registers the live count, tallies F->0 roll-overs and scans a 2-digit
// 7-segment display: digit 0 = live count, digit 1 = roll-over tally.
module count_scan_display #(
    parameter int SCAN_DIV       = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    count_scan_display_if.slave  bus
);
    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

    // Hex to gfedcba, then polarity for common-anode boards.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return ACTIVE_LOW_SEG ? ~s : s;
    endfunction

    logic [3:0]       q_r_q, q_r_d;
    logic [3:0]       q_prev_q, q_prev_d;
    logic [3:0]       wraps_q, wraps_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sel_q, sel_d;
    logic [1:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             rollover;

    // Next-state: input pipeline, roll-over tally, scan divider, display drive.
    // The display mux reads wraps_q, so a roll-over on a digit-1 edge shows
    // the pre-increment tally until the next digit-1 refresh.
    always_comb begin
        q_r_d        = bus.q;
        q_prev_d     = q_r_q;
        rollover     = (q_prev_q == 4'hF) && (q_r_q == 4'h0);
        wrap_pulse_d = rollover;
        wraps_d      = rollover ? wraps_q + 4'd1 : wraps_q;

        div_cnt_d = div_cnt_q + 1'b1;
        sel_d     = sel_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            sel_d     = ~sel_q;
        end

        an_d  = 2'b00;
        seg_d = SEG_OFF;
        if (!bus.blank) begin
            if (!sel_q) begin
                an_d  = 2'b01;
                seg_d = seg_of(q_r_q);
            end else begin
                an_d  = 2'b10;
                seg_d = seg_of(wraps_q);
            end
        end
    end

    // State registers; reset clears everything and blanks the display at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r_q        <= '0;
            q_prev_q     <= '0;
            wraps_q      <= '0;
            wrap_pulse_q <= 1'b0;
            div_cnt_q    <= '0;
            sel_q        <= 1'b0;
            an_q         <= 2'b00;
            seg_q        <= SEG_OFF;
        end else begin
            q_r_q        <= q_r_d;
            q_prev_q     <= q_prev_d;
            wraps_q      <= wraps_d;
            wrap_pulse_q <= wrap_pulse_d;
            div_cnt_q    <= div_cnt_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.wraps      = wraps_q;
    assign bus.wrap_pulse = wrap_pulse_q;
endmodule
